range_capture: RTL and testbench

- Upstream feeder of the address-range circular buffer.
- Watches the commit-stage CSR write stream for the allocation protocol: write base CSR, then write size CSR.
- Converts each {base, size} pair into an inclusive {first, last} address range and issues a one-cycle write strobe to the buffer.
- Also generates the buffer's synchronous clear and reports protocol errors to the security monitor.

---
 rtl/range_capture_pkg.sv | 15 +
 rtl/range_capture.sv | 92 +++++++++
 tb/tb_range_capture.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/range_capture_pkg.sv
// range_capture_pkg: shared types and default CSR addresses for the range capture block
package range_capture_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SIZE, EMIT} state_t;
  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ORPHAN  = 3'd1,
    ERR_ZERO    = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_OVF     = 3'd4
  } err_code_t;
  localparam logic [11:0] BASE_CSR_DEF = 12'h7C0;
  localparam logic [11:0] SIZE_CSR_DEF = 12'h7C1;
  localparam logic [11:0] CTRL_CSR_DEF = 12'h7C2;
  localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/range_capture.sv
// range_capture: turns committed base/size CSR writes into inclusive address-range pushes
module range_capture
  import range_capture_pkg::*;
#(
  parameter logic [11:0] BASE_CSR = BASE_CSR_DEF,
  parameter logic [11:0] SIZE_CSR = SIZE_CSR_DEF,
  parameter logic [11:0] CTRL_CSR = CTRL_CSR_DEF,
  parameter int          TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmt_valid_i,
  input  logic [11:0] cmt_csr_addr_i,
  input  logic [31:0] cmt_csr_wdata_i,
  output logic        en_write_o,
  output logic [31:0] addr_first_o,
  output logic [31:0] addr_last_o,
  output logic        clear_o,
  output logic        err_o,
  output logic [2:0]  err_code_o,
  output logic [5:0]  count_o
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  state_t state_q, state_d;
  err_code_t code_q, code_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0] base_q, base_d, first_d, last_d;
  logic [32:0] sum;
  logic [5:0] cnt_d;
  logic hit_ctrl, hit_base, hit_size, size_zero, timeout, emit;
  logic orphan, zero, ovf, tmo, en_d, err_d;
  assign hit_ctrl  = cmt_valid_i && cmt_csr_addr_i == CTRL_CSR && cmt_csr_wdata_i[0];
  assign hit_base  = cmt_valid_i && cmt_csr_addr_i == BASE_CSR;
  assign hit_size  = cmt_valid_i && cmt_csr_addr_i == SIZE_CSR;
  assign size_zero = cmt_csr_wdata_i == 32'd0;
  assign timeout   = timer_q == TW'(TIMEOUT - 1);
  assign sum       = {1'b0, base_q} + {1'b0, cmt_csr_wdata_i} - 33'd1;
  assign err_code_o = code_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:      state_d = hit_base ? WAIT_SIZE : IDLE;
      WAIT_SIZE: state_d = hit_base ? WAIT_SIZE : hit_size ? (size_zero ? IDLE : EMIT) : timeout ? IDLE : WAIT_SIZE;
      EMIT:      state_d = hit_base ? WAIT_SIZE : IDLE;
      default:   state_d = IDLE;
    endcase
    if (hit_ctrl) state_d = IDLE;
  end
  always_comb begin
    emit    = state_d == EMIT;
    en_d    = emit;
    base_d  = hit_base ? cmt_csr_wdata_i : base_q;
    timer_d = hit_base ? '0 : (state_q == WAIT_SIZE ? timer_q + 1'b1 : timer_q);
    orphan  = hit_size && state_q != WAIT_SIZE;
    zero    = hit_size && state_q == WAIT_SIZE && size_zero;
    ovf     = emit && sum[32];
    tmo     = state_q == WAIT_SIZE && timeout && !(hit_ctrl || hit_base || hit_size);
    err_d   = orphan || zero || ovf || tmo;
    code_d  = hit_ctrl ? ERR_NONE : orphan ? ERR_ORPHAN : zero ? ERR_ZERO :
              tmo ? ERR_TIMEOUT : ovf ? ERR_OVF : code_q;
    first_d = emit ? base_q : addr_first_o;
    last_d  = emit ? (sum[32] ? 32'hFFFF_FFFF : sum[31:0]) : addr_last_o;
    cnt_d   = hit_ctrl ? 6'd0 : (emit && count_o != 6'd63) ? count_o + 6'd1 : count_o;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q       <= '0;
      timer_q      <= '0;
      code_q       <= ERR_NONE;
      en_write_o   <= 1'b0;
      addr_first_o <= '0;
      addr_last_o  <= '0;
      clear_o      <= 1'b0;
      err_o        <= 1'b0;
      count_o      <= '0;
    end else begin
      base_q       <= base_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      en_write_o   <= en_d;
      addr_first_o <= first_d;
      addr_last_o  <= last_d;
      clear_o      <= hit_ctrl;
      err_o        <= err_d;
      count_o      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_range_capture.sv
// tb_range_capture: scoreboard bench; stimulus pushes expected events, a monitor pops on every DUT event
module tb_range_capture;
  typedef struct {
    logic        en;
    logic        err;
    logic        clr;
    logic [31:0] first;
    logic [31:0] last;
    logic [2:0]  code;
    logic [5:0]  cnt;
  } ev_t;
  localparam logic [11:0] B = 12'h7C0, S = 12'h7C1, C = 12'h7C2;
  logic clk_i = 0, rst_i = 1, cmt_valid_i = 0;
  logic [11:0] cmt_csr_addr_i = '0;
  logic [31:0] cmt_csr_wdata_i = '0;
  logic en_write_o, clear_o, err_o;
  logic [31:0] addr_first_o, addr_last_o;
  logic [2:0] err_code_o;
  logic [5:0] count_o;
  int checks = 0, errors = 0;
  ev_t q[$];
  range_capture dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmt_valid_i(cmt_valid_i),
    .cmt_csr_addr_i(cmt_csr_addr_i), .cmt_csr_wdata_i(cmt_csr_wdata_i),
    .en_write_o(en_write_o), .addr_first_o(addr_first_o), .addr_last_o(addr_last_o),
    .clear_o(clear_o), .err_o(err_o), .err_code_o(err_code_o), .count_o(count_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic en, input logic err, input logic clr, input logic [31:0] f,
                      input logic [31:0] l, input logic [2:0] code, input logic [5:0] cnt);
    ev_t e;
    e.en = en; e.err = err; e.clr = clr; e.first = f; e.last = l; e.code = code; e.cnt = cnt;
    q.push_back(e);
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cmt_valid_i = 1; cmt_csr_addr_i = a; cmt_csr_wdata_i = d;
    @(posedge clk_i); #1;
    cmt_valid_i = 0; cmt_csr_addr_i = '0; cmt_csr_wdata_i = '0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask
  initial forever begin
    @(negedge clk_i);
    if (!rst_i && (en_write_o || err_o || clear_o)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: en=%b err=%b clr=%b code=%0d at %0t",
                 en_write_o, err_o, clear_o, err_code_o, $time);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("en_write", 32'(en_write_o), 32'(e.en));
        chk("err", 32'(err_o), 32'(e.err));
        chk("clear", 32'(clear_o), 32'(e.clr));
        chk("err_code", 32'(err_code_o), 32'(e.code));
        chk("count", 32'(count_o), 32'(e.cnt));
        if (e.en) begin
          chk("addr_first", addr_first_o, e.first);
          chk("addr_last", addr_last_o, e.last);
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #2;
    chk("reset_outputs", {en_write_o, err_o, clear_o, err_code_o, count_o, addr_first_o[15:0]}, '0);
    idle(2);
    rst_i = 0;
    idle(1);
    // nominal range
    wr(B, 32'h8000_1000);
    push(1, 0, 0, 32'h8000_1000, 32'h8000_103F, 3'd0, 6'd1);
    wr(S, 32'h40);
    idle(2);
    // end address wraps past 2^32: saturate and flag, still pushed
    wr(B, 32'hFFFF_FFF0);
    push(1, 1, 0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 3'd4, 6'd2);
    wr(S, 32'h20);
    idle(2);
    chk("first_hold", addr_first_o, 32'hFFFF_FFF0);
    wr(B, 32'h1000);
    push(0, 1, 0, 0, 0, 3'd2, 6'd2);
    wr(S, 32'h0);
    idle(2);
    // timeout: err must appear exactly on the 64th edge after the base write
    wr(B, 32'h5000);
    idle(63);
    chk("timeout_early", 32'(err_o), 32'd0);
    push(0, 1, 0, 0, 0, 3'd3, 6'd2);
    idle(1);
    chk("timeout_now", 32'(err_o), 32'd1);
    idle(2);
    push(0, 1, 0, 0, 0, 3'd1, 6'd2);
    wr(S, 32'h10);
    idle(2);
    wr(B, 32'h6000);
    idle(3);
    push(0, 0, 1, 0, 0, 3'd0, 6'd0);
    wr(C, 32'h1);
    idle(2);
    push(0, 1, 0, 0, 0, 3'd1, 6'd0);
    wr(S, 32'h10);
    idle(2);
    wr(C, 32'h0);
    idle(2);
    wr(B, 32'h2000);
    push(1, 0, 0, 32'h2000, 32'h2000, 3'd1, 6'd1);
    wr(S, 32'h1);
    idle(2);
    // reset in the middle of a capture
    wr(B, 32'h3000);
    #2 rst_i = 1;
    #1;
    chk("rst_mid_outputs", {en_write_o, err_o, clear_o, err_code_o, count_o}, '0);
    chk("rst_mid_addr", addr_last_o, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 0;
    idle(1);
    push(0, 1, 0, 0, 0, 3'd1, 6'd0);
    wr(S, 32'h10);
    idle(2);
    for (int i = 0; i < 64; i++) begin
      logic [31:0] b;
      b = 32'h0001_0000 + 32'(i) * 32'h100;
      push(1, 0, 0, b, b + 32'hF, 3'd1, (i + 1 > 63) ? 6'd63 : 6'(i + 1));
      wr(B, b);
      wr(S, 32'h10);
    end
    idle(4);
    chk("count_saturated", 32'(count_o), 32'd63);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
